// File: rtl/role_hit_tracker.sv
// Player/enemy contact tracker: one contact decision per frame, HP, invincibility blink, game over.
// Decisions take effect one cycle after the frame tick; no backpressure, inputs are sampled every cycle.
module role_hit_tracker #(
    parameter int MAX_Y      = 480,
    parameter int HP_MAX     = 5,
    parameter int INV_FRAMES = 90,
    parameter int BLINK_BIT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       jojo_on,
    input  logic       enemy_on,
    input  logic       restart,
    output logic [2:0] hp,
    output logic       hit_pulse,
    output logic       invincible,
    output logic       jojo_visible,
    output logic       game_over
);
    typedef enum logic [1:0] {S_ALIVE, S_HIT, S_DEAD} state_t;

    localparam logic [9:0] LP_MAX_Y = 10'(MAX_Y);
    localparam logic [2:0] LP_HP    = 3'(HP_MAX);
    localparam logic [7:0] LP_INV   = 8'(INV_FRAMES);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_hp, w_hp_nxt;
    logic [7:0] r_inv_cnt, w_inv_nxt;
    logic       r_ovl, w_ovl_nxt;
    logic       r_hit_pulse, w_pulse_nxt;
    logic       r_at_end_d;
    logic       r_armed;
    logic       w_at_end, w_tick, w_set;
    logic       w_unused_x;

    assign w_unused_x = ^x;
    assign w_at_end   = (y == LP_MAX_Y);
    // r_armed suppresses a tick when y already sits on MAX_Y as reset releases
    assign w_tick     = w_at_end & ~r_at_end_d & r_armed;
    assign w_set      = jojo_on & enemy_on & (y < LP_MAX_Y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_ALIVE;
            r_hp        <= LP_HP;
            r_inv_cnt   <= 8'd0;
            r_ovl       <= 1'b0;
            r_hit_pulse <= 1'b0;
            r_at_end_d  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hp        <= w_hp_nxt;
            r_inv_cnt   <= w_inv_nxt;
            r_ovl       <= w_ovl_nxt;
            r_hit_pulse <= w_pulse_nxt;
            r_at_end_d  <= w_at_end;
            r_armed     <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hp_nxt    = r_hp;
        w_inv_nxt   = r_inv_cnt;
        w_ovl_nxt   = r_ovl;
        w_pulse_nxt = 1'b0;
        if (restart) begin
            w_state_nxt = S_ALIVE;
            w_hp_nxt    = LP_HP;
            w_inv_nxt   = 8'd0;
            w_ovl_nxt   = 1'b0;
        end else begin
            if (w_tick) begin
                w_ovl_nxt = 1'b0;
            end else if (w_set) begin
                w_ovl_nxt = 1'b1;
            end
            if (w_tick) begin
                case (r_state)
                    S_ALIVE: begin
                        if (r_ovl) begin
                            w_pulse_nxt = 1'b1;
                            if (r_hp > 3'd1) begin
                                w_hp_nxt    = r_hp - 3'd1;
                                w_inv_nxt   = LP_INV;
                                w_state_nxt = S_HIT;
                            end else begin
                                w_hp_nxt    = 3'd0;
                                w_state_nxt = S_DEAD;
                            end
                        end
                    end
                    S_HIT: begin
                        if (r_inv_cnt == 8'd1) begin
                            w_inv_nxt   = 8'd0;
                            w_state_nxt = S_ALIVE;
                        end else begin
                            w_inv_nxt = r_inv_cnt - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign hp           = r_hp;
    assign hit_pulse    = r_hit_pulse;
    assign invincible   = (r_state == S_HIT);
    assign game_over    = (r_state == S_DEAD);
    assign jojo_visible = (r_state != S_HIT) | ~r_inv_cnt[BLINK_BIT];
endmodule

// File: tb/tb_role_hit_tracker.sv
// Randomized frame-level bench for role_hit_tracker with three parameter sets sharing one stimulus.
// Expected outputs come from a frame-rule model of HP / invincibility / death.
module tb_role_hit_tracker;
    localparam int ND = 3;
    localparam int P_HP  [ND] = '{5, 5, 2};
    localparam int P_INV [ND] = '{90, 4, 4};
    localparam int P_BL  [ND] = '{3, 2, 0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       jojo_on = 1'b0, enemy_on = 1'b0, restart = 1'b0;
    logic [2:0] w_hp  [ND];
    logic       w_pulse [ND];
    logic       w_inv [ND];
    logic       w_vis [ND];
    logic       w_go  [ND];

    always #5 clk = ~clk;

    role_hit_tracker #(.MAX_Y(480), .HP_MAX(5), .INV_FRAMES(90), .BLINK_BIT(3)) dut0 (
        .clk(clk), .reset(reset), .x(x), .y(y), .jojo_on(jojo_on), .enemy_on(enemy_on),
        .restart(restart), .hp(w_hp[0]), .hit_pulse(w_pulse[0]), .invincible(w_inv[0]),
        .jojo_visible(w_vis[0]), .game_over(w_go[0]));
    role_hit_tracker #(.MAX_Y(480), .HP_MAX(5), .INV_FRAMES(4), .BLINK_BIT(2)) dut1 (
        .clk(clk), .reset(reset), .x(x), .y(y), .jojo_on(jojo_on), .enemy_on(enemy_on),
        .restart(restart), .hp(w_hp[1]), .hit_pulse(w_pulse[1]), .invincible(w_inv[1]),
        .jojo_visible(w_vis[1]), .game_over(w_go[1]));
    role_hit_tracker #(.MAX_Y(480), .HP_MAX(2), .INV_FRAMES(4), .BLINK_BIT(0)) dut2 (
        .clk(clk), .reset(reset), .x(x), .y(y), .jojo_on(jojo_on), .enemy_on(enemy_on),
        .restart(restart), .hp(w_hp[2]), .hit_pulse(w_pulse[2]), .invincible(w_inv[2]),
        .jojo_visible(w_vis[2]), .game_over(w_go[2]));

    int n_tests = 0;
    int n_fail  = 0;

    // model: hit points, frames of invincibility left, dead flag, contact seen this frame
    int   m_hp  [ND];
    int   m_inv [ND];
    bit   m_dead [ND];
    bit   m_pulse [ND];
    bit   seen;
    int   prev_y;
    int   pulse_cnt [ND];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_restore();
        for (int i = 0; i < ND; i++) begin
            m_hp[i]    = P_HP[i];
            m_inv[i]   = 0;
            m_dead[i]  = 1'b0;
            m_pulse[i] = 1'b0;
        end
        seen = 1'b0;
    endtask

    task automatic check_all();
        for (int i = 0; i < ND; i++) begin
            check($sformatf("hp[%0d]", i), int'(w_hp[i]), m_hp[i]);
            check($sformatf("hit_pulse[%0d]", i), int'(w_pulse[i]), int'(m_pulse[i]));
            check($sformatf("invincible[%0d]", i), int'(w_inv[i]), int'(m_inv[i] > 0));
            check($sformatf("game_over[%0d]", i), int'(w_go[i]), int'(m_dead[i]));
            check($sformatf("jojo_visible[%0d]", i), int'(w_vis[i]),
                  int'((m_inv[i] == 0) || (((m_inv[i] >> P_BL[i]) & 1) == 0)));
        end
    endtask

    task automatic step(input int yv, input bit j, input bit e, input bit rst);
        bit tick;
        @(negedge clk);
        y = 10'(yv);
        x = 10'($urandom_range(0, 639));
        jojo_on = j;
        enemy_on = e;
        restart = rst;
        @(posedge clk);
        #1;
        tick = (yv == 480) && (prev_y != 480);
        prev_y = yv;
        for (int i = 0; i < ND; i++) m_pulse[i] = 1'b0;
        if (rst) begin
            model_restore();
        end else if (tick) begin
            for (int i = 0; i < ND; i++) begin
                if (m_dead[i]) begin
                end else if (m_inv[i] > 0) begin
                    m_inv[i]--;
                end else if (seen) begin
                    m_hp[i]--;
                    m_pulse[i] = 1'b1;
                    if (m_hp[i] == 0) m_dead[i] = 1'b1;
                    else m_inv[i] = P_INV[i];
                end
            end
            seen = 1'b0;
        end else if (j && e && yv < 480) begin
            seen = 1'b1;
        end
        for (int i = 0; i < ND; i++) pulse_cnt[i] += int'(w_pulse[i]);
        check_all();
    endtask

    // mode 0: never overlap, 1: overlap once in the visible area, 2: random incl. restarts
    task automatic frame(input int mode, input bit rst_at_tick);
        int vis, k, n;
        bit j, e, r;
        vis = $urandom_range(2, 10);
        k = $urandom_range(0, vis - 1);
        for (int c = 0; c < vis; c++) begin
            j = 1'($urandom);
            e = 1'($urandom);
            if (mode == 0) e = e & ~j;
            if (mode == 1 && c == k) begin j = 1'b1; e = 1'b1; end
            r = (mode == 2) && ($urandom_range(0, 59) == 0);
            step($urandom_range(0, 479), j, e, r);
        end
        n = $urandom_range(1, 5);
        for (int c = 0; c < n; c++) step(480, 1'($urandom), 1'($urandom), (c == 0) && rst_at_tick);
        n = $urandom_range(0, 2);
        for (int c = 0; c < n; c++) step($urandom_range(481, 1023), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        prev_y = 0;
        for (int i = 0; i < ND; i++) pulse_cnt[i] = 0;
        model_restore();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // single contact at y=100, then the tick
        step(50, 1'b0, 1'b1, 1'b0);
        step(100, 1'b1, 1'b1, 1'b0);
        step(200, 1'b1, 1'b0, 1'b0);
        step(480, 1'b0, 1'b0, 1'b0);
        check("single_hp0", int'(w_hp[0]), 4);
        check("single_pulse0", int'(w_pulse[0]), 1);
        step(480, 1'b0, 1'b0, 1'b0);
        check("single_pulse_off0", int'(w_pulse[0]), 0);
        step(300, 1'b0, 1'b0, 1'b0);

        // sustained contact every frame
        for (int f = 0; f < 150; f++) frame(1, 1'b0);
        check("dead_before_restart", int'(w_go[2]), 1);

        // restart in DEAD at a tick where the latch is set
        frame(1, 1'b1);
        check("restart_hp2", int'(w_hp[2]), 2);

        for (int f = 0; f < 250; f++) frame($urandom_range(0, 2), ($urandom_range(0, 29) == 0));

        // hold y at MAX_Y far longer than a pixel: exactly one tick
        frame(2, 1'b1);
        step(100, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < ND; i++) pulse_cnt[i] = 0;
        for (int c = 0; c < 4000; c++) step(480, 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < ND; i++) check($sformatf("hold_pulses[%0d]", i), int'(pulse_cnt[i] <= 1), 1);
        for (int c = 0; c < 20; c++) step($urandom_range(481, 1023), 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) frame(0, 1'b0);

        // async reset in the middle of an invincibility window
        frame(2, 1'b1);
        frame(1, 1'b0);
        step(10, 1'b0, 1'b0, 1'b0);
        check("pre_reset_inv0", int'(w_inv[0]), 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_restore();
        check_all();
        @(negedge clk);
        y = 10'd0;
        jojo_on = 1'b0;
        enemy_on = 1'b0;
        restart = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_y = 0;
        for (int f = 0; f < 20; f++) frame($urandom_range(0, 2), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
